button_press_decoder: RTL

Front-end stage of the scoreboard. It converts the raw, asynchronous, bouncing pushbutton into clean single-cycle count events for the up/down score counter. It contains a two-flop synchronizer, a debounce filter and a press-duration classifier:
- short press -> count_up_o pulse on release
- long press -> count_down_o pulse when the hold threshold is reached, with optional auto-repeat
It runs on the 1 kHz system clock, so all time parameters are in milliseconds (clock cycles).

---
 rtl/button_press_decoder.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/button_press_decoder.sv
// Pushbutton front end: two-flop synchronizer, debounce filter and press-duration classifier.
// A short press pulses count_up_o on release; a long press pulses count_down_o at the threshold and on each repeat.
module button_press_decoder #(
    parameter int DEBOUNCE_MS     = 20,
    parameter int LONG_MS         = 1000,
    parameter int REPEAT_MS       = 0,
    parameter bit BTN_ACTIVE_HIGH = 1'b1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic pushbutton_i,
    output logic count_up_o,
    output logic count_down_o,
    output logic pressed_o
);
    localparam int MAX_LR = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
    localparam int MAX_T  = (MAX_LR > DEBOUNCE_MS) ? MAX_LR : DEBOUNCE_MS;
    localparam int CW     = $clog2(MAX_T + 1);

    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] DEB_TGT  = CW'(DEBOUNCE_MS);
    localparam logic [CW-1:0] LONG_TGT = CW'(LONG_MS);
    localparam logic [CW-1:0] REP_TGT  = CW'(REPEAT_MS);
    localparam bit            DEB_ONE  = (DEBOUNCE_MS <= 1);

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        SHORT_HELD,
        DEB_REL_SHORT,
        LONG_HELD,
        DEB_REL_LONG
    } state_t;

    state_t        r_state, w_stateNext;
    logic          r_sync1, r_sync2;
    logic          w_btnRaw, w_btnS;
    logic [CW-1:0] r_debCnt, r_holdCnt;
    logic [CW-1:0] w_debNext, w_holdNext, w_debInc, w_holdInc;
    logic          r_up, r_down, r_pressed;
    logic          w_upNext, w_downNext, w_pressedNext;

    assign w_btnRaw  = BTN_ACTIVE_HIGH ? pushbutton_i : ~pushbutton_i;
    assign w_btnS    = r_sync2;
    assign w_debInc  = (r_debCnt == CNT_MAX) ? r_debCnt : r_debCnt + CNT_ONE;
    assign w_holdInc = (r_holdCnt == CNT_MAX) ? r_holdCnt : r_holdCnt + CNT_ONE;

    // Reset loads the released level so a button held through reset needs a full new debounce.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= w_btnRaw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= IDLE;
            r_debCnt  <= '0;
            r_holdCnt <= '0;
            r_up      <= 1'b0;
            r_down    <= 1'b0;
            r_pressed <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_debCnt  <= w_debNext;
            r_holdCnt <= w_holdNext;
            r_up      <= w_upNext;
            r_down    <= w_downNext;
            r_pressed <= w_pressedNext;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_debNext     = r_debCnt;
        w_holdNext    = r_holdCnt;
        w_upNext      = 1'b0;
        w_downNext    = 1'b0;
        w_pressedNext = r_pressed;
        case (r_state)
            IDLE: begin
                if (w_btnS) begin
                    if (DEB_ONE) begin
                        w_stateNext   = SHORT_HELD;
                        w_pressedNext = 1'b1;
                        w_holdNext    = '0;
                    end else begin
                        w_stateNext = DEB_PRESS;
                        w_debNext   = CNT_ONE;
                    end
                end
            end
            DEB_PRESS: begin
                if (!w_btnS) begin
                    w_stateNext = IDLE;
                    w_debNext   = '0;
                end else if (w_debInc == DEB_TGT) begin
                    w_stateNext   = SHORT_HELD;
                    w_pressedNext = 1'b1;
                    w_holdNext    = '0;
                    w_debNext     = '0;
                end else begin
                    w_debNext = w_debInc;
                end
            end
            // Threshold is checked before release so a simultaneous fall still counts as long.
            SHORT_HELD: begin
                if (w_holdInc == LONG_TGT) begin
                    w_downNext = 1'b1;
                    w_holdNext = '0;
                    if (w_btnS) begin
                        w_stateNext = LONG_HELD;
                    end else if (DEB_ONE) begin
                        w_stateNext   = IDLE;
                        w_pressedNext = 1'b0;
                    end else begin
                        w_stateNext = DEB_REL_LONG;
                        w_debNext   = CNT_ONE;
                    end
                end else begin
                    w_holdNext = w_holdInc;
                    if (!w_btnS) begin
                        if (DEB_ONE) begin
                            w_stateNext   = IDLE;
                            w_pressedNext = 1'b0;
                            w_upNext      = 1'b1;
                            w_holdNext    = '0;
                        end else begin
                            w_stateNext = DEB_REL_SHORT;
                            w_debNext   = CNT_ONE;
                        end
                    end
                end
            end
            DEB_REL_SHORT: begin
                if (w_btnS) begin
                    w_stateNext = SHORT_HELD;
                    w_debNext   = '0;
                end else if (w_debInc == DEB_TGT) begin
                    w_stateNext   = IDLE;
                    w_pressedNext = 1'b0;
                    w_upNext      = 1'b1;
                    w_debNext     = '0;
                    w_holdNext    = '0;
                end else begin
                    w_debNext = w_debInc;
                end
            end
            LONG_HELD: begin
                if (REPEAT_MS > 0) begin
                    if (w_holdInc == REP_TGT) begin
                        w_downNext = 1'b1;
                        w_holdNext = '0;
                    end else begin
                        w_holdNext = w_holdInc;
                    end
                end
                if (!w_btnS) begin
                    if (DEB_ONE) begin
                        w_stateNext   = IDLE;
                        w_pressedNext = 1'b0;
                        w_holdNext    = '0;
                    end else begin
                        w_stateNext = DEB_REL_LONG;
                        w_debNext   = CNT_ONE;
                    end
                end
            end
            DEB_REL_LONG: begin
                if (w_btnS) begin
                    w_stateNext = LONG_HELD;
                    w_debNext   = '0;
                end else if (w_debInc == DEB_TGT) begin
                    w_stateNext   = IDLE;
                    w_pressedNext = 1'b0;
                    w_debNext     = '0;
                    w_holdNext    = '0;
                end else begin
                    w_debNext = w_debInc;
                end
            end
            default: begin
                w_stateNext   = IDLE;
                w_debNext     = '0;
                w_holdNext    = '0;
                w_pressedNext = 1'b0;
            end
        endcase
    end

    assign count_up_o   = r_up;
    assign count_down_o = r_down;
    assign pressed_o    = r_pressed;
endmodule
